// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: copies a byte block through a start/done memory port.
// Define COPY_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES.
module mem_copy_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_src,
   input  logic [7:0] cmd_dst,
   input  logic [7:0] cmd_len,
   output logic       busy,
   output logic       copy_done,
   output logic [7:0] copied,
   output logic       err,
   output logic       mem_start,
   output logic [1:0] mem_op,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic       mem_done,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
   } state_e;

   localparam logic [1:0] OpRd = 2'b01;
   localparam logic [1:0] OpWr = 2'b00;

   state_e     state_q;
   logic       cmd_ready_q;
   logic       busy_q;
   logic       copy_done_q;
   logic [7:0] copied_q;
   logic       mem_start_q;
   logic [1:0] mem_op_q;
   logic [7:0] mem_addr_q;
   logic [7:0] mem_wdata_q;
   logic [7:0] src_q;
   logic [7:0] dst_q;
   logic [7:0] rem_q;
   logic [7:0] src_d;
   logic       tmo;

   assign src_d = src_q + 8'd1;

`ifdef COPY_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wcnt_q;
   logic          err_q;
   logic          waiting;

   assign waiting = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   assign tmo     = (wcnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   // Counter is zero outside wait states, so every REQ restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (waiting) wcnt_q <= wcnt_q + CW'(1);
         else         wcnt_q <= '0;
         if (state_q == IDLE && cmd_valid) err_q <= 1'b0;
         else if (waiting && !mem_done && tmo) err_q <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   // keeps the parameter referenced when the watchdog is compiled out
   assign err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         copy_done_q <= 1'b0;
         copied_q    <= 8'd0;
         mem_start_q <= 1'b0;
         mem_op_q    <= OpRd;
         mem_addr_q  <= 8'd0;
         mem_wdata_q <= 8'd0;
         src_q       <= 8'd0;
         dst_q       <= 8'd0;
         rem_q       <= 8'd0;
      end else begin
         mem_start_q <= 1'b0;
         copy_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  src_q       <= cmd_src;
                  dst_q       <= cmd_dst;
                  rem_q       <= cmd_len;
                  copied_q    <= 8'd0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_len == 8'd0) begin
                     state_q     <= FINISH;
                     copy_done_q <= 1'b1;
                  end else begin
                     state_q     <= RD_REQ;
                     mem_start_q <= 1'b1;
                     mem_op_q    <= OpRd;
                     mem_addr_q  <= cmd_src;
                  end
               end
            end
            RD_REQ: state_q <= RD_WAIT;
            RD_WAIT: begin
               if (mem_done) begin
                  state_q     <= WR_REQ;
                  mem_start_q <= 1'b1;
                  mem_op_q    <= OpWr;
                  mem_addr_q  <= dst_q;
                  mem_wdata_q <= mem_rdata;
               end else if (tmo) begin
                  state_q     <= FINISH;
                  copy_done_q <= 1'b1;
               end
            end
            WR_REQ: state_q <= WR_WAIT;
            WR_WAIT: begin
               if (mem_done) begin
                  src_q    <= src_d;
                  dst_q    <= dst_q + 8'd1;
                  copied_q <= copied_q + 8'd1;
                  rem_q    <= rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
                     state_q     <= FINISH;
                     copy_done_q <= 1'b1;
                  end else begin
                     state_q     <= RD_REQ;
                     mem_start_q <= 1'b1;
                     mem_op_q    <= OpRd;
                     mem_addr_q  <= src_d;
                  end
               end else if (tmo) begin
                  state_q     <= FINISH;
                  copy_done_q <= 1'b1;
               end
            end
            FINISH: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign copy_done = copy_done_q;
   assign copied    = copied_q;
   assign mem_start = mem_start_q;
   assign mem_op    = mem_op_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// tb_mem_copy_initiator: scoreboard bench with a latency-programmable memory.
`timescale 1ns/1ps
module tb_mem_copy_initiator;

   localparam int TMO = 8;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_src;
   logic [7:0] cmd_dst;
   logic [7:0] cmd_len;
   logic       busy;
   logic       copy_done;
   logic [7:0] copied;
   logic       err;
   logic       mem_start;
   logic [1:0] mem_op;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_done;
   logic [7:0] mem_rdata;

   typedef struct {
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       exp_q[$];
   logic [7:0] mem[256];
   logic [7:0] model[256];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_start = 0;
   int n_done = 0;
   int rd_cnt = 0;
   int rd_lat = 1;
   int wr_lat = 1;
   int hang_rd = 0;
   bit spur = 0;
   bit pend = 0;
   int cnt = 0;
   logic [1:0] p_op;
   logic [7:0] p_addr;
   logic [7:0] p_wdata;

   mem_copy_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .busy(busy), .copy_done(copy_done), .copied(copied), .err(err),
      .mem_start(mem_start), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   // Memory responder: pops the scoreboard on each start pulse.
   initial begin
      txn_t e;
      mem_done  = 0;
      mem_rdata = 0;
      forever begin
         @(negedge clk);
         if (copy_done === 1'b1) n_done++;
         mem_done = spur;
         if (rst) begin
            pend = 0;
         end else if (mem_start === 1'b1) begin
            n_start++;
            p_op = mem_op;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
            if (mem_op == 2'b01) rd_cnt++;
            cnt = (mem_op == 2'b01) ? rd_lat : wr_lat;
            if (mem_op == 2'b01 && rd_cnt == hang_rd) cnt = -1;
            pend = 1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL txn_extra got op %b addr %0d, no transaction expected",
                        mem_op, mem_addr);
            end else begin
               e = exp_q.pop_front();
               if (mem_op !== e.op || mem_addr !== e.addr ||
                   (e.op == 2'b00 && mem_wdata !== e.data)) begin
                  errors++;
                  $display("FAIL txn got op %b addr %0d data %0d want op %b addr %0d data %0d",
                           mem_op, mem_addr, mem_wdata, e.op, e.addr, e.data);
               end
            end
         end else if (pend) begin
            checks++;
            if (mem_op !== p_op || mem_addr !== p_addr || mem_wdata !== p_wdata) begin
               errors++;
               $display("FAIL txn_hold got op %b addr %0d data %0d want op %b addr %0d data %0d",
                        mem_op, mem_addr, mem_wdata, p_op, p_addr, p_wdata);
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  mem_done = 1;
                  pend = 0;
                  if (p_op == 2'b01) mem_rdata = mem[p_addr];
                  else mem[p_addr] = p_wdata;
               end
            end
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      mem[a] = v;
      model[a] = v;
   endtask

   task automatic resync();
      foreach (mem[i]) model[i] = mem[i];
   endtask

   task automatic push_copy(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] v;
      for (int i = 0; i < int'(l); i++) begin
         a = s + 8'(i);
         b = d + 8'(i);
         v = model[a];
         exp_q.push_back('{2'b01, a, 8'd0});
         exp_q.push_back('{2'b00, b, v});
         model[b] = v;
      end
   endtask

   task automatic issue_cmd(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, output int acc);
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k == 1000) begin
         checks++;
         errors++;
         $display("FAIL cmd_ready_wait got %b want 1", cmd_ready);
      end
      push_copy(s, d, l);
      cmd_src = s;
      cmd_dst = d;
      cmd_len = l;
      cmd_valid = 1;
      @(negedge clk);
      acc = cyc;
      cmd_valid = 0;
   endtask

   task automatic wait_done(output int fin, output bit tout);
      tout = 1;
      fin = 0;
      for (int k = 0; k < 2000; k++) begin
         if (copy_done === 1'b1) begin
            fin = cyc;
            tout = 0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      cmd_valid = 0;
      cmd_src = 0;
      cmd_dst = 0;
      cmd_len = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, busy, copy_done, err, mem_start} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags got rdy/busy/done/err/start %b want 10000",
                  {cmd_ready, busy, copy_done, err, mem_start});
      end
      checks++;
      if (copied !== 8'd0 || mem_op !== 2'b01 || mem_addr !== 8'd0 || mem_wdata !== 8'd0) begin
         errors++;
         $display("FAIL reset_regs got copied %0d op %b addr %0d wdata %0d want 0 01 0 0",
                  copied, mem_op, mem_addr, mem_wdata);
      end
      rst = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got rdy %b busy %b want 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_basic();
      int acc, fin, s0, d0;
      bit tout;
      for (int i = 0; i < 4; i++) preload(8'(10 + i), 8'(42 + i));
      rd_lat = 1;
      wr_lat = 1;
      s0 = n_start;
      d0 = n_done;
      issue_cmd(8'd10, 8'd100, 8'd4, acc);
      wait_done(fin, tout);
      checks++;
      if (tout || fin - acc != 16) begin
         errors++;
         $display("FAIL basic_latency got %0d timeout %0d want 16", fin - acc, tout);
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[100 + i] !== 8'(42 + i)) begin
            errors++;
            $display("FAIL basic_mem[%0d] got %0d want %0d", 100 + i, mem[100 + i], 42 + i);
         end
      end
      checks++;
      if (copied !== 8'd4 || n_done - d0 != 1 || n_start - s0 != 8) begin
         errors++;
         $display("FAIL basic_counts got copied %0d pulses %0d starts %0d want 4 1 8",
                  copied, n_done - d0, n_start - s0);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_queue got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_latency();
      int acc, fin;
      bit tout;
      rd_lat = 3;
      wr_lat = 2;
      issue_cmd(8'd10, 8'd150, 8'd3, acc);
      wait_done(fin, tout);
      checks++;
      if (tout || fin - acc != 21) begin
         errors++;
         $display("FAIL wait_latency got %0d timeout %0d want 21", fin - acc, tout);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (mem[152] !== 8'd44 || copied !== 8'd3) begin
         errors++;
         $display("FAIL wait_data got mem %0d copied %0d want 44 3", mem[152], copied);
      end
      rd_lat = 1;
      wr_lat = 1;
   endtask

   task automatic test_zero_len();
      int acc, fin, s0;
      bit tout;
      s0 = n_start;
      issue_cmd(8'd5, 8'd6, 8'd0, acc);
      wait_done(fin, tout);
      checks++;
      if (tout || fin != acc) begin
         errors++;
         $display("FAIL zero_len_latency got %0d timeout %0d want 0", fin - acc, tout);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n_start != s0 || copied !== 8'd0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_len_state got starts %0d copied %0d rdy %b want 0 0 1",
                  n_start - s0, copied, cmd_ready);
      end
   endtask

   task automatic test_wrap();
      int acc, fin;
      bit tout;
      preload(8'd254, 8'hA1);
      preload(8'd255, 8'hB2);
      preload(8'd0, 8'hC3);
      issue_cmd(8'd254, 8'd0, 8'd3, acc);
      wait_done(fin, tout);
      repeat (2) @(negedge clk);
      checks++;
      if (tout || mem[0] !== 8'hA1 || mem[1] !== 8'hB2 || mem[2] !== 8'hA1) begin
         errors++;
         $display("FAIL wrap_mem got %h %h %h timeout %0d want a1 b2 a1",
                  mem[0], mem[1], mem[2], tout);
      end
      checks++;
      if (copied !== 8'd3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_count got copied %0d left %0d want 3 0", copied, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int acc, fin, r0, d0, k;
      bit tout;
      for (int i = 0; i < 5; i++) preload(8'(30 + i), 8'(7 * i + 3));
      rd_lat = 4;
      r0 = rd_cnt;
      issue_cmd(8'd30, 8'd60, 8'd5, acc);
      k = 0;
      while (rd_cnt < r0 + 2 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(negedge clk);
      #2;
      d0 = n_done;
      rst = 1;
      #1;
      checks++;
      if (k == 200 || busy !== 1'b0 || mem_start !== 1'b0 ||
          cmd_ready !== 1'b1 || copy_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got busy %b start %b rdy %b done %b want 0 0 1 0",
                  busy, mem_start, cmd_ready, copy_done);
      end
      repeat (2) @(negedge clk);
      exp_q.delete();
      pend = 0;
      resync();
      rst = 0;
      repeat (4) @(negedge clk);
      checks++;
      if (n_done != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet got pulses %0d busy %b want 0 0", n_done - d0, busy);
      end
      rd_lat = 1;
      preload(8'd40, 8'h5A);
      preload(8'd41, 8'hC6);
      issue_cmd(8'd40, 8'd80, 8'd2, acc);
      wait_done(fin, tout);
      repeat (2) @(negedge clk);
      checks++;
      if (tout || mem[80] !== 8'h5A || mem[81] !== 8'hC6 || copied !== 8'd2) begin
         errors++;
         $display("FAIL reset_mid_after got %h %h copied %0d timeout %0d want 5a c6 2",
                  mem[80], mem[81], copied, tout);
      end
   endtask

   task automatic test_spurious_busy();
      int acc, fin, s0, d0;
      bit tout;
      logic [7:0] c0;
      s0 = n_start;
      d0 = n_done;
      c0 = copied;
      spur = 1;
      repeat (3) @(negedge clk);
      spur = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || n_start != s0 ||
          copied !== c0 || n_done != d0) begin
         errors++;
         $display("FAIL spurious_done got busy %b rdy %b starts %0d copied %0d pulses %0d want 0 1 0 %0d 0",
                  busy, cmd_ready, n_start - s0, copied, n_done - d0, c0);
      end
      preload(8'd20, 8'h11);
      preload(8'd21, 8'h22);
      issue_cmd(8'd20, 8'd170, 8'd2, acc);
      cmd_src = 8'd0;
      cmd_dst = 8'd200;
      cmd_len = 8'd9;
      cmd_valid = 1;
      repeat (3) @(negedge clk);
      cmd_valid = 0;
      wait_done(fin, tout);
      repeat (6) @(negedge clk);
      checks++;
      if (tout || n_start - s0 != 4 || n_done - d0 != 1 || copied !== 8'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore got starts %0d pulses %0d copied %0d busy %b want 4 1 2 0",
                  n_start - s0, n_done - d0, copied, busy);
      end
      checks++;
      if (mem[170] !== 8'h11 || mem[171] !== 8'h22) begin
         errors++;
         $display("FAIL busy_ignore_mem got %h %h want 11 22", mem[170], mem[171]);
      end
   endtask

`ifdef COPY_TIMEOUT_EN
   task automatic test_timeout();
      int acc, fin, d0;
      bit tout;
      for (int i = 0; i < 3; i++) preload(8'(50 + i), 8'(90 + i));
      d0 = n_done;
      hang_rd = rd_cnt + 2;
      issue_cmd(8'd50, 8'd90, 8'd3, acc);
      wait_done(fin, tout);
      checks++;
      if (tout || fin - acc != 13) begin
         errors++;
         $display("FAIL timeout_latency got %0d timeout %0d want 13", fin - acc, tout);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1 || copied !== 8'd1 || n_done - d0 != 1) begin
         errors++;
         $display("FAIL timeout_state got err %b copied %0d pulses %0d want 1 1 1",
                  err, copied, n_done - d0);
      end
      hang_rd = 0;
      pend = 0;
      exp_q.delete();
      resync();
      issue_cmd(8'd50, 8'd95, 8'd1, acc);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear got err %b want 0", err);
      end
      wait_done(fin, tout);
      repeat (2) @(negedge clk);
      checks++;
      if (tout || copied !== 8'd1 || mem[95] !== 8'd90 || err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_next got copied %0d mem %0d err %b want 1 90 0",
                  copied, mem[95], err);
      end
   endtask
`endif

   initial begin
      foreach (mem[i]) begin
         mem[i] = 8'(i ^ 8'h5C);
         model[i] = mem[i];
      end
      test_reset();
      test_basic();
      test_latency();
      test_zero_len();
      test_wrap();
      test_reset_mid();
      test_spurious_busy();
`ifdef COPY_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_copy_initiator.md
# mem_copy_initiator

Command-driven initiator for the `multicycle_memory` start/done interface. It copies a block of bytes from a source address to a destination address by issuing alternating read and write transactions, one at a time, and waits for `done` on each. It sits between control logic, which issues one copy command, and the multicycle memory, whose `start/op/addr/write_data/done/read_data` port set it drives from the master side.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum wait-state cycles per memory transaction. Used only when `COPY_TIMEOUT_EN` is defined.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: copy command present.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_src` in 8: first source address.
- `cmd_dst` in 8: first destination address.
- `cmd_len` in 8: byte count, 0–255.
- `busy` out 1: high in every state except IDLE.
- `copy_done` out 1: one-cycle pulse at the end of each command.
- `copied` out 8: bytes fully written for the current or last command.
- `err` out 1: timeout abort flag. Tied 0 without the macro.
- `mem_start` out 1: one-cycle transaction start pulse.
- `mem_op` out 2: `2'b01` = read, `2'b00` = write. Other codes are never driven.
- `mem_addr` out 8: transaction address.
- `mem_wdata` out 8: write data.
- `mem_done` in 1: transaction complete. Sampled only in wait states.
- `mem_rdata` in 8: read data, valid on the `mem_done` cycle of a read.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- **IDLE**, on command accept:
  - Latch `cmd_src`, `cmd_dst` and `cmd_len`.
  - Clear `copied` and `err`.
  - Go to FINISH if `cmd_len == 0`, otherwise go to RD_REQ.
- **RD_REQ**: assert `mem_start` with `mem_op = 01` and `mem_addr = src`, then go to RD_WAIT.
- **RD_WAIT**:
  - Hold `mem_op` and `mem_addr` stable.
  - On `mem_done`, capture `mem_rdata` into the data register and go to WR_REQ.
- **WR_REQ**: assert `mem_start` with `mem_op = 00`, `mem_addr = dst` and `mem_wdata = data`, then go to WR_WAIT.
- **WR_WAIT**: hold `mem_op`, `mem_addr` and `mem_wdata` stable. On `mem_done`:
  - Increment `src`, `dst` and `copied`; decrement the remaining count.
  - Go to FINISH if the remaining count reaches 0, otherwise go to RD_REQ.
- **FINISH**: pulse `copy_done` for one cycle, then go to IDLE.
- Address arithmetic is 8-bit modulo. For example, `src = 8'hFF` is followed by `8'h00`. No error is raised on wrap.
- Overlapping regions are copied in ascending order byte by byte. No overlap correction is performed.
- `mem_done` seen in IDLE, RD_REQ, WR_REQ or FINISH is ignored.
- `cmd_valid` while busy is ignored; the command is not queued.
- Reset at any point, including mid-transaction: return to IDLE immediately. No completion pulse is generated for an aborted command.

## Timing
- Reset values:
  - state IDLE, `cmd_ready` 1, `busy` 0, `copy_done` 0, `copied` 0, `err` 0.
  - `mem_start` 0, `mem_op` `2'b01`, `mem_addr` 0, `mem_wdata` 0.
- All outputs are registered.
- `mem_start` is high for exactly one cycle per transaction: the REQ-state cycle.
- Per-byte cost is `2 + Wr + Ww` cycles.
  - Wr and Ww count the wait-state cycles up to and including the cycle `mem_done` is sampled high.
  - The minimum is 4 cycles, with `mem_done` on the first wait cycle.
- Command total is `1 + N*(2 + Wr + Ww) + 1` cycles from accept to the `copy_done` cycle. For N = 0 it is 2 cycles.
- The next command can be accepted on the cycle after `copy_done`.

## Configuration
- `COPY_TIMEOUT_EN` defined:
  - A wait counter runs in RD_WAIT and WR_WAIT and clears on each REQ.
  - If it reaches `TIMEOUT_CYCLES` without `mem_done`, set `err = 1` and go to FINISH. `copy_done` still pulses.
  - `copied` holds the number of fully completed bytes.
  - `err` stays high until the next command is accepted or reset.
- `COPY_TIMEOUT_EN` undefined: no counter; wait states wait indefinitely; `err` is constant 0.

## Test plan
- Fill the memory with `mem[10..13] = 42, 43, 44, 45`, then issue src = 10, dst = 100, len = 4.
  - Required: reads and writes strictly alternate.
  - Required: `mem[100..103] = 42..45`, `copied = 4`, and one `copy_done` pulse.
  - Required: `mem_start` pulse count is 8.
- Issue len = 0 -> `copy_done` 2 cycles after accept, no `mem_start`, `copied = 0`.
- Issue src = 254, dst = 0, len = 3 -> reads at 254, 255 and 0.
  - Required: writes at 0, 1 and 2, with the byte written to 0 being the original `mem[254]`.
- Reset mid-transaction: assert `rst` during the second RD_WAIT of a len = 5 copy.
  - Required: same cycle -> `busy = 0`, `mem_start = 0`, `cmd_ready = 1`, no `copy_done`.
  - Required: a new command then completes normally.
- With `COPY_TIMEOUT_EN` and `TIMEOUT_CYCLES = 8`, hold `mem_done` low on the second read of a len = 3 copy.
  - Required: `err = 1`, `copied = 1`, one `copy_done` pulse.
  - Required: the next accepted command clears `err`.
- Drive a spurious `mem_done` in IDLE, and `cmd_valid` while busy.
  - Required: no state change and no second command executed.
